// File: rtl/data_req_arbiter_pkg.sv
// Shared source ids and sizing constants for the data request arbiter.
package data_req_arbiter_pkg;
   localparam logic SRC_M1S  = 1'b0;
   localparam logic SRC_WBUF = 1'b1;
   localparam int DATA_REQ_TAG_W      = 1;
   localparam int OUTSTANDING_DEFAULT = 4;

   typedef enum logic {
      ST_FREE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;
endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of source ids for accepted-but-unanswered requests.
module arb_tag_fifo
   import data_req_arbiter_pkg::*;
#(
   parameter int DEPTH = OUTSTANDING_DEFAULT
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      push,
   input  logic                      push_id,
   input  logic                      pop,
   output logic                      full,
   output logic                      empty,
   output logic                      head,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic             mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push is allowed even when full.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_id;
   end
endmodule

// File: rtl/data_req_arbiter.sv
// Two-source arbiter for the data SRAM port: MEM1 stage vs. write-buffer drain,
// with grant hold on downstream stall and in-order response routing.
module data_req_arbiter
   import data_req_arbiter_pkg::*;
#(
   parameter int OUTSTANDING = OUTSTANDING_DEFAULT,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              m_req,
   input  logic              m_wr,
   input  logic [1:0]        m_size,
   input  logic [3:0]        m_wstrb,
   input  logic [DATA_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_wdata,
   input  logic              m_uncache,
   output logic              m_addr_ok,
   output logic              m_data_ok,
   input  logic              w_req,
   input  logic              w_wr,
   input  logic [1:0]        w_size,
   input  logic [3:0]        w_wstrb,
   input  logic [DATA_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_wdata,
   input  logic              w_uncache,
   input  logic              w_urgent,
   output logic              w_addr_ok,
   output logic              w_data_ok,
   output logic              data_sram_req,
   output logic              data_sram_wr,
   output logic [1:0]        data_sram_size,
   output logic [3:0]        data_sram_wstrb,
   output logic [DATA_W-1:0] data_sram_addr,
   output logic [DATA_W-1:0] data_sram_wdata,
   output logic              data_uncache,
   input  logic              data_sram_addr_ok,
   input  logic              data_sram_data_ok,
   input  logic [DATA_W-1:0] data_sram_rdata,
   output logic [DATA_W-1:0] rdata,
   output logic              arb_idle,
   output logic              arb_err
);
   arb_state_e state_q, state_d;
   logic       lock_id_q, lock_id_d;
   logic       grant_valid, grant_id, sel_req, lock_drop, accept;
   logic       fifo_full, fifo_empty, fifo_head, pop;
   logic [$clog2(OUTSTANDING):0] fifo_count;

   // Lock state machine: the grant is frozen while a presented request stalls.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_FREE;
         lock_id_q <= SRC_M1S;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
      end
   end

   always_comb begin
      grant_valid = 1'b0;
      grant_id    = SRC_M1S;
      state_d     = ST_FREE;
      lock_id_d   = lock_id_q;
      // Outputs stay quiet while reset is asserted, even mid-lock.
      if (!resetn) begin
         grant_valid = 1'b0;
      end else if (state_q == ST_LOCKED) begin
         grant_valid = 1'b1;
         grant_id    = lock_id_q;
      end else if (!fifo_full) begin
         if (w_req && (w_urgent || !m_req)) begin
            grant_valid = 1'b1;
            grant_id    = SRC_WBUF;
         end else if (m_req) begin
            grant_valid = 1'b1;
            grant_id    = SRC_M1S;
         end
      end
      sel_req       = (grant_id == SRC_WBUF) ? w_req : m_req;
      data_sram_req = grant_valid && sel_req;
      lock_drop     = (state_q == ST_LOCKED) && !sel_req;
      accept        = data_sram_req && data_sram_addr_ok;
      if (data_sram_req && !data_sram_addr_ok) begin
         state_d   = ST_LOCKED;
         lock_id_d = grant_id;
      end
   end

   always_comb begin
      data_sram_wr    = 1'b0;
      data_sram_size  = '0;
      data_sram_wstrb = '0;
      data_sram_addr  = '0;
      data_sram_wdata = '0;
      data_uncache    = 1'b0;
      if (data_sram_req && grant_id == SRC_WBUF) begin
         data_sram_wr    = w_wr;
         data_sram_size  = w_size;
         data_sram_wstrb = w_wstrb;
         data_sram_addr  = w_addr;
         data_sram_wdata = w_wdata;
         data_uncache    = w_uncache;
      end else if (data_sram_req) begin
         data_sram_wr    = m_wr;
         data_sram_size  = m_size;
         data_sram_wstrb = m_wstrb;
         data_sram_addr  = m_addr;
         data_sram_wdata = m_wdata;
         data_uncache    = m_uncache;
      end
   end

   assign m_addr_ok = accept && (grant_id == SRC_M1S);
   assign w_addr_ok = accept && (grant_id == SRC_WBUF);
   assign pop       = data_sram_data_ok && !fifo_empty;
   assign m_data_ok = pop && (fifo_head == SRC_M1S);
   assign w_data_ok = pop && (fifo_head == SRC_WBUF);
   assign rdata     = data_sram_rdata;
   assign arb_idle  = fifo_empty && (state_q == ST_FREE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                                          arb_err <= 1'b0;
      else if (lock_drop || (data_sram_data_ok && fifo_empty)) arb_err <= 1'b1;
   end

   arb_tag_fifo #(.DEPTH(OUTSTANDING)) u_tag_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push    (accept),
      .push_id (grant_id),
      .pop     (pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head),
      .count   (fifo_count)
   );

   logic unused_count;
   assign unused_count = ^fifo_count;
endmodule

// File: tb/tb_data_req_arbiter.sv
// Directed bench for data_req_arbiter: grant priority, lock hold, full FIFO,
// response routing, protocol error and async reset.
module tb_data_req_arbiter;
   logic        clk = 1'b0;
   logic        resetn;
   logic        m_req, m_wr, m_uncache, w_req, w_wr, w_uncache, w_urgent;
   logic [1:0]  m_size, w_size;
   logic [3:0]  m_wstrb, w_wstrb;
   logic [31:0] m_addr, m_wdata, w_addr, w_wdata;
   logic        m_addr_ok, m_data_ok, w_addr_ok, w_data_ok;
   logic        data_sram_req, data_sram_wr, data_uncache;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata, rdata;
   logic        data_sram_addr_ok, data_sram_data_ok, arb_idle, arb_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   data_req_arbiter #(.OUTSTANDING(4), .DATA_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_uncache(m_uncache),
      .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
      .w_req(w_req), .w_wr(w_wr), .w_size(w_size), .w_wstrb(w_wstrb),
      .w_addr(w_addr), .w_wdata(w_wdata), .w_uncache(w_uncache),
      .w_urgent(w_urgent), .w_addr_ok(w_addr_ok), .w_data_ok(w_data_ok),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_uncache(data_uncache), .data_sram_addr_ok(data_sram_addr_ok),
      .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
      .rdata(rdata), .arb_idle(arb_idle), .arb_err(arb_err)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Move to the next falling edge; inputs are changed there, outputs sampled 1ns later.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      m_req = 0; m_wr = 0; m_size = 2'd2; m_wstrb = 4'hF; m_addr = '0; m_wdata = '0; m_uncache = 0;
      w_req = 0; w_wr = 1; w_size = 2'd2; w_wstrb = 4'hF; w_addr = '0; w_wdata = '0; w_uncache = 1;
      w_urgent = 0; data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = '0;
   endtask

   initial begin
      clear_inputs();
      resetn = 0;
      #1;
      check_val("rst_req", data_sram_req, 0);
      check_val("rst_addr_ok", {m_addr_ok, w_addr_ok}, 0);
      check_val("rst_data_ok", {m_data_ok, w_data_ok}, 0);
      check_val("rst_idle", arb_idle, 1);
      check_val("rst_err", arb_err, 0);
      next_cycle();
      resetn = 1;

      // Single m request accepted at once, answered three cycles later.
      next_cycle();
      m_req = 1; m_addr = 32'h100; m_wdata = 32'h11; data_sram_addr_ok = 1;
      #1;
      check_val("t1_req", data_sram_req, 1);
      check_val("t1_m_addr_ok", m_addr_ok, 1);
      check_val("t1_w_addr_ok", w_addr_ok, 0);
      check_val("t1_addr", data_sram_addr, 32'h100);
      check_val("t1_wdata", data_sram_wdata, 32'h11);
      next_cycle();
      m_req = 0; data_sram_addr_ok = 0;
      #1;
      check_val("t1_busy", arb_idle, 0);
      check_val("t1_no_fields", data_sram_addr, 0);
      next_cycle();
      next_cycle();
      data_sram_data_ok = 1; data_sram_rdata = 32'hDEADBEEF;
      #1;
      check_val("t1_m_data_ok", m_data_ok, 1);
      check_val("t1_w_data_ok", w_data_ok, 0);
      check_val("t1_rdata", rdata, 32'hDEADBEEF);
      next_cycle();
      data_sram_data_ok = 0;
      #1;
      check_val("t1_idle", arb_idle, 1);

      // Both request: m wins unless w is urgent.
      m_req = 1; m_addr = 32'h200; w_req = 1; w_addr = 32'h300; data_sram_addr_ok = 1;
      #1;
      check_val("t2_m_wins", data_sram_addr, 32'h200);
      check_val("t2_m_ok", {m_addr_ok, w_addr_ok}, 2'b10);
      next_cycle();
      w_urgent = 1;
      #1;
      check_val("t2_w_wins", data_sram_addr, 32'h300);
      check_val("t2_w_ok", {m_addr_ok, w_addr_ok}, 2'b01);
      check_val("t2_w_uncache", data_uncache, 1);
      next_cycle();
      m_req = 0; w_req = 0; w_urgent = 0; data_sram_addr_ok = 0; data_sram_data_ok = 1;
      #1;
      check_val("t2_resp0", {m_data_ok, w_data_ok}, 2'b10);
      next_cycle();
      #1;
      check_val("t2_resp1", {m_data_ok, w_data_ok}, 2'b01);
      next_cycle();
      data_sram_data_ok = 0;
      #1;
      check_val("t2_idle", arb_idle, 1);

      // Stalled w grant is held while m_req / w_urgent toggle.
      w_req = 1; w_urgent = 1; w_addr = 32'h300; m_addr = 32'h200;
      #1;
      check_val("t3_stall0", data_sram_addr, 32'h300);
      check_val("t3_no_ok", {m_addr_ok, w_addr_ok}, 0);
      next_cycle();
      m_req = 1; w_urgent = 0;
      #1;
      check_val("t3_stall1", data_sram_addr, 32'h300);
      check_val("t3_locked_busy", arb_idle, 0);
      next_cycle();
      m_req = 0; w_urgent = 1;
      #1;
      check_val("t3_stall2", data_sram_addr, 32'h300);
      next_cycle();
      m_req = 1; w_urgent = 0; data_sram_addr_ok = 1;
      #1;
      check_val("t3_accept_addr", data_sram_addr, 32'h300);
      check_val("t3_accept_ok", {m_addr_ok, w_addr_ok}, 2'b01);
      next_cycle();
      m_req = 0; w_req = 0; data_sram_addr_ok = 0; data_sram_data_ok = 1;
      #1;
      check_val("t3_resp", {m_data_ok, w_data_ok}, 2'b01);
      next_cycle();
      data_sram_data_ok = 0;
      #1;
      check_val("t3_unlocked_idle", arb_idle, 1);
      check_val("t3_no_err", arb_err, 0);

      // Four outstanding fill the tag FIFO and block further grants.
      m_req = 1; m_addr = 32'h400; data_sram_addr_ok = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_val($sformatf("t4_fill%0d", i), m_addr_ok, 1);
         next_cycle();
      end
      w_req = 1; w_urgent = 1;
      #1;
      check_val("t4_full_req", data_sram_req, 0);
      check_val("t4_full_ok", {m_addr_ok, w_addr_ok}, 0);
      next_cycle();
      w_req = 0; w_urgent = 0; data_sram_data_ok = 1;
      #1;
      check_val("t4_full_pop_req", data_sram_req, 0);
      check_val("t4_full_pop_resp", m_data_ok, 1);
      next_cycle();
      data_sram_data_ok = 0;
      #1;
      check_val("t4_resume", m_addr_ok, 1);
      next_cycle();
      m_req = 0; data_sram_addr_ok = 0; data_sram_data_ok = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_val($sformatf("t4_drain%0d", i), {m_data_ok, w_data_ok}, 2'b10);
         next_cycle();
      end
      data_sram_data_ok = 0;
      #1;
      check_val("t4_idle", arb_idle, 1);

      // Accept order m,w,m, then responses overlapping a new w accept.
      m_req = 1; data_sram_addr_ok = 1;
      next_cycle();
      m_req = 0; w_req = 1;
      next_cycle();
      m_req = 1; w_req = 0;
      next_cycle();
      m_req = 0; w_req = 1; data_sram_data_ok = 1;
      #1;
      check_val("t5_overlap_accept", w_addr_ok, 1);
      check_val("t5_resp0", {m_data_ok, w_data_ok}, 2'b10);
      next_cycle();
      w_req = 0; data_sram_addr_ok = 0;
      #1;
      check_val("t5_resp1", {m_data_ok, w_data_ok}, 2'b01);
      next_cycle();
      #1;
      check_val("t5_resp2", {m_data_ok, w_data_ok}, 2'b10);
      next_cycle();
      data_sram_data_ok = 0;
      #1;
      check_val("t5_one_left", arb_idle, 0);
      next_cycle();
      data_sram_data_ok = 1;
      #1;
      check_val("t5_last", {m_data_ok, w_data_ok}, 2'b01);
      next_cycle();
      data_sram_data_ok = 0;
      #1;
      check_val("t5_idle", arb_idle, 1);

      // Response with nothing outstanding is a protocol error.
      data_sram_data_ok = 1;
      #1;
      check_val("t6_spurious", {m_data_ok, w_data_ok}, 0);
      next_cycle();
      data_sram_data_ok = 0;
      #1;
      check_val("t6_err", arb_err, 1);
      check_val("t6_still_idle", arb_idle, 1);

      // Reset asserted while a request is locked.
      m_req = 1; m_addr = 32'h500;
      next_cycle();
      #1;
      check_val("t7_locked", arb_idle, 0);
      resetn = 0;
      #1;
      check_val("t7_rst_req", data_sram_req, 0);
      check_val("t7_rst_err", arb_err, 0);
      check_val("t7_rst_idle", arb_idle, 1);
      next_cycle();
      clear_inputs();
      resetn = 1;
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/data_req_arbiter.md
Name: data_req_arbiter

Overview:
- Shares the single data SRAM-like port between two requesters: the MEM1 stage load/store path (source 0, "m") and the store write buffer drain (source 1, "w").
- Selects one requester per cycle and holds the grant while a downstream request stalls.
- Records the source of every accepted request in an in-order tag FIFO, and routes each data_ok response back to the right requester.
- Sits between the MEM1 stage / write buffer and the cache/AXI bridge.

Parameters:
- OUTSTANDING, 4, max accepted-but-unanswered requests; power of 2, minimum 2.
- DATA_W, 32, address/data width.

Ports:
- clk  in  1  core clock.
- resetn  in  1  reset, asynchronous, active-low.
- m_req  in  1  MEM1 request valid.
- m_wr  in  1  MEM1 write.
- m_size  in  2  MEM1 access size.
- m_wstrb  in  4  MEM1 byte strobes.
- m_addr  in  DATA_W  MEM1 address.
- m_wdata  in  DATA_W  MEM1 write data.
- m_uncache  in  1  MEM1 uncached attribute.
- m_addr_ok  out  1  MEM1 request accepted.
- m_data_ok  out  1  MEM1 response valid.
- w_req, w_wr, w_size, w_wstrb, w_addr, w_wdata, w_uncache  in  same widths as the m_* inputs  write-buffer request.
- w_urgent  in  1  write buffer full; raises its priority.
- w_addr_ok  out  1  write-buffer request accepted.
- w_data_ok  out  1  write-buffer response valid.
- data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata, data_uncache  out  as above  downstream request.
- data_sram_addr_ok  in  1  downstream accepted.
- data_sram_data_ok  in  1  downstream response.
- data_sram_rdata  in  DATA_W  downstream read data.
- rdata  out  DATA_W  data_sram_rdata broadcast to both requesters.
- arb_idle  out  1  tag FIFO empty and no lock.
- arb_err  out  1  sticky protocol error.

Behaviour:
- Request path and addr_ok are combinational; zero added latency.
- Reset (resetn low, asynchronous): tag FIFO empty, count=0, lock=0, arb_err=0.
  - Resulting outputs: data_sram_req=0, m_addr_ok=m_data_ok=w_addr_ok=w_data_ok=0, arb_idle=1.
- Selection when unlocked:
  - If count==OUTSTANDING: no grant; data_sram_req=0, both addr_ok=0.
  - Otherwise pick w if w_req && (w_urgent || !m_req); else m if m_req; else none.
- Downstream outputs carry the granted source's fields; data_sram_req = granted source's req.
- When no source is granted, data fields are driven 0.
- Lock:
  - Set: data_sram_req && !data_sram_addr_ok sets lock=1 and lock_id = granted id for the next cycle.
  - Hold: while locked, the grant is forced to lock_id, regardless of the other req, w_urgent, or FIFO count. The count was checked when the grant was first made.
  - Clear: lock clears on addr_ok.
  - If the locked source drops req: data_sram_req=0, lock clears, arb_err is set.
- Accept: data_sram_req && data_sram_addr_ok.
  - Raises the granted source's addr_ok only; the other source's addr_ok stays 0.
  - Pushes the 1-bit source id into the tag FIFO.
- Response: data_sram_data_ok pops the FIFO head.
  - Raises m_data_ok if head==0, w_data_ok if head==1, in the same cycle.
  - rdata is always data_sram_rdata.
- data_ok with the FIFO empty: ignored (no *_data_ok, no pop); arb_err set.
- Same-cycle push and pop: count unchanged; the head is popped before the new tag is visible.
  - An accept and a response for the same source in one cycle are therefore legal.
- FIFO pointers wrap modulo OUTSTANDING.
- count runs 0..OUTSTANDING.
- arb_idle = (count==0) && !lock.
- arb_err clears only on reset.

Decomposition:
- Shared package: SRC_M1S=1'b0, SRC_WBUF=1'b1, and the constants DATA_REQ_TAG_W / OUTSTANDING_DEFAULT.
- One sub-module: arb_tag_fifo.
  - Synchronous FIFO of 1-bit ids with push, pop, full, empty, head, and count.
  - Async active-low reset.

Test Plan:
- m_req=1 only, addr_ok=1 same cycle -> m_addr_ok=1, w_addr_ok=0, FIFO count 1; 3 cycles later data_ok with rdata=0xDEADBEEF -> m_data_ok=1, rdata=0xDEADBEEF, arb_idle=1.
- m_req and w_req both 1, w_urgent=0 -> m granted (data_sram_addr=m_addr). Repeat with w_urgent=1 -> w granted.
- w granted, addr_ok held 0 for 3 cycles, then m_req and w_urgent toggle -> downstream keeps w_addr. On the 4th-cycle addr_ok: w_addr_ok=1, lock cleared.
- OUTSTANDING=4: 4 accepts without data_ok -> data_sram_req=0 despite m_req=1. One data_ok -> next-cycle grant resumes.
- Accept order m,w,m, then 3 data_ok pulses, with data_ok coinciding with a new w accept -> m_data_ok, w_data_ok, m_data_ok in order; count ends at 1.
- data_ok with empty FIFO -> no *_data_ok, arb_err=1. resetn pulsed low mid-lock -> immediately data_sram_req=0, arb_err=0, arb_idle=1.
